serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor: computes D = A − B over WIDTH clock cycles, LSB first, using a single half/full-subtractor bit slice and a registered borrow. Counterpart to the team's adder blocks: it implements the subtraction direction of the same add/subtract datapath. It also serves as the sequential building block for the lab's serial ALU exercises. A start/busy/done handshake launches each operation and reports its completion.

---
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, start/busy/done handshake
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Encoding chosen so busy and done are plain state flop bits.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] ra, rb, rd, rd_nxt;
    logic             bor;
    logic [CW-1:0]    cnt;
    logic             a, b, d, bor_nxt;

    assign busy = state[1];
    assign done = state[0];

    always_comb begin
        a       = ra[0];
        b       = rb[0];
        d       = a ^ b ^ bor;
        bor_nxt = (~a & b) | (~(a ^ b) & bor);
        rd_nxt  = rd >> 1;
        rd_nxt[WIDTH-1] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            rd   <= '0;
            bor  <= 1'b0;
            cnt  <= '0;
            D    <= '0;
            Bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= A;
                        rb  <= B;
                        bor <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rd  <= rd_nxt;
                    bor <= bor_nxt;
                    cnt <= cnt + CW'(1);
                    // Results are published only on the last bit so D/Bout never show partial data.
                    if (cnt == LAST) begin
                        D    <= rd_nxt;
                        Bout <= bor_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed-vector bench for serial_subtractor
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             busy, done;
    logic [WIDTH-1:0] D;
    logic             Bout;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                         input logic eb, input bit disturb);
        logic [7:0] prev_d;
        int  lat, busyc, dchg, got, extra;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        prev_d = D;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; busyc = 0; dchg = 0; got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (busy) busyc++;
            if (done) got = 1;
            else begin
                lat++;
                if (D !== prev_d) dchg = 1;
            end
            if (disturb) begin
                A = ~A;
                B = B + 8'h35;
                start = (i == 2);
                if (i == 2) begin
                    A = 8'h01;
                    B = 8'h01;
                end
            end
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("latency", lat, WIDTH);
        check("busy_cycles", busyc, WIDTH + 1);
        check("d_held", dchg, 0);
        check("d_value", D, ed);
        check("bout_value", Bout, eb);
        @(negedge clk);
        check("done_drop", done, 0);
        check("busy_drop", busy, 0);
        if (disturb) begin
            extra = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("no_extra_done", extra, 0);
            check("d_after_ignore", D, ed);
        end
    endtask

    initial begin
        int prev_c, pulses;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", D, 0);
        check("rst_bout", Bout, 0);
        rst_n = 1'b1;

        do_op(8'h35, 8'h12, 8'h23, 1'b0, 0);
        do_op(8'h12, 8'h35, 8'hDD, 1'b1, 0);
        do_op(8'h00, 8'h01, 8'hFF, 1'b1, 0);
        do_op(8'hAA, 8'hAA, 8'h00, 1'b0, 0);
        do_op(8'hFF, 8'h00, 8'hFF, 1'b0, 0);
        do_op(8'h5C, 8'h3A, 8'h22, 1'b0, 1);

        // Abort mid-operation via async reset
        @(negedge clk);
        A = 8'h80; B = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_d", D, 0);
        check("abort_bout", Bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h80, 8'h01, 8'h7F, 1'b0, 0);

        // Continuous start: one accept per WIDTH+2 cycles
        @(negedge clk);
        A = 8'h10; B = 8'h20; start = 1'b1;
        prev_c = -1; pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("held_d", D, 8'hF0);
                check("held_bout", Bout, 1);
                if (prev_c >= 0) check("held_spacing", c - prev_c, WIDTH + 2);
                prev_c = c;
            end
        end
        start = 1'b0;
        check("held_pulses", pulses, 3);
        repeat (12) @(negedge clk);
        check("held_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
